// File: rtl/rv32_pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pipeline_pkg: shared types and constants for the RV32IM pipeline |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32_pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_pipeline_reg: IF/ID instruction, PC and valid register          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_id_pipeline_reg
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  // Flush wins over load so a redirect always leaves a bubble behind it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_instr <= BUBBLE_INSTR;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= BUBBLE_INSTR;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_unit: IF stage (PC, imem handshake, IF/ID register) |
// | Optional macro IF_PERF_CNT_EN adds FETCH_COUNT / STALL_COUNT ports.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_fetch_unit
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        INSTR_MEM_READ,
  output logic [31:0] INSTR_MEM_ADDRESS,
  input  logic [31:0] INSTR_MEM_READDATA,
  input  logic        INSTR_MEM_BUSYWAIT,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        HOLD,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_VALID,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] STALL_COUNT,
`endif
  output logic        FETCH_BUSY
);

  fetch_state_t r_state;
  logic         r_read;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;

  logic         w_fetch_busy;
  logic         w_capture;
  logic [31:0]  w_target;

  assign w_fetch_busy = r_read & INSTR_MEM_BUSYWAIT;
  assign w_capture    = r_read & ~INSTR_MEM_BUSYWAIT & ~HOLD & ~BRANCH_TAKEN
                      & (r_state != S_DRAIN);
  assign w_target     = align_word(BRANCH_TARGET);

  // r_pc always holds the next fetch address; while draining, the bus keeps
  // presenting the abandoned address until the memory lets go of it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_FETCH;
      r_read       <= 1'b0;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      r_read <= 1'b1;
      if (BRANCH_TAKEN) begin
        r_pc <= w_target;
        if (r_state != S_DRAIN) begin
          r_drain_addr <= r_pc;
        end
        r_state <= w_fetch_busy ? S_DRAIN : S_FETCH;
      end else begin
        case (r_state)
          S_FETCH, S_WAIT: begin
            if (w_fetch_busy) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_FETCH;
              if (w_capture) begin
                r_pc <= r_pc + PC_STEP;
              end
            end
          end
          S_DRAIN: begin
            if (!w_fetch_busy) begin
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign INSTR_MEM_READ    = r_read;
  assign INSTR_MEM_ADDRESS = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign FETCH_BUSY        = w_fetch_busy;

  if_id_pipeline_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_load  (w_capture),
    .i_flush (BRANCH_TAKEN),
    .i_instr (INSTR_MEM_READDATA),
    .i_pc    (r_pc),
    .o_instr (IF_ID_INSTRUCTION),
    .o_pc    (IF_ID_PC),
    .o_valid (IF_ID_VALID)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_capture) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_fetch_busy || HOLD) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign FETCH_COUNT = r_fetch_count;
  assign STALL_COUNT = r_stall_count;
`endif

endmodule
`default_nettype wire
